// File: rtl/seq_det_pkg.sv
// Shared types, default widths and width helpers for the serial sequence detector controller.
package seq_det_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam int DEF_MAX_LEN = 8;
  localparam int DEF_CNT_W   = 8;
  localparam int DEF_TMO_W   = 16;

  // Bits needed to hold a pattern length in 0..max_len.
  function automatic int len_w(input int max_len);
    return $clog2(max_len + 1);
  endfunction

endpackage

// File: rtl/seq_det_match_core.sv
// Shift register, fill counter and masked pattern compare with a registered match pulse.
// SEQ_DET_NONOVERLAP_EN: restart the fill count after every match (non-overlapping detection).
module seq_det_match_core
  import seq_det_pkg::*;
#(
  parameter int MAX_LEN = DEF_MAX_LEN,
  localparam int LEN_W = len_w(MAX_LEN)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clr,
  input  logic               in_valid,
  input  logic               in,
  input  logic [MAX_LEN-1:0] pattern,
  input  logic [LEN_W-1:0]   len,
  output logic               match,
  output logic               match_nxt
);

  localparam logic [LEN_W-1:0] FILL_MAX = LEN_W'(MAX_LEN);

  logic [MAX_LEN-1:0] sr_q, sr_d, mask_s;
  logic [LEN_W-1:0]   fill_q, fill_d, fill_inc_s;
  logic               match_q, match_d;

  // Mask selecting the low len bits of the shift register.
  always_comb begin
    mask_s = '0;
    for (int i = 0; i < MAX_LEN; i++) begin
      if (i < int'(len)) mask_s[i] = 1'b1;
      else               mask_s[i] = 1'b0;
    end
  end

  // Shift, fill tracking and compare against the newest len bits.
  always_comb begin
    sr_d       = sr_q;
    fill_d     = fill_q;
    fill_inc_s = fill_q;
    match_d    = 1'b0;
    if (clr) begin
      sr_d   = '0;
      fill_d = '0;
    end else if (in_valid) begin
      sr_d = {sr_q[MAX_LEN-2:0], in};
      if (fill_q < FILL_MAX) fill_inc_s = fill_q + LEN_W'(1);
      else                   fill_inc_s = fill_q;
      if ((fill_inc_s >= len) && (((sr_d ^ pattern) & mask_s) == '0)) match_d = 1'b1;
      else                                                            match_d = 1'b0;
`ifdef SEQ_DET_NONOVERLAP_EN
      if (match_d) fill_d = '0;
      else         fill_d = fill_inc_s;
`else
      fill_d = fill_inc_s;
`endif
    end else begin
      sr_d   = sr_q;
      fill_d = fill_q;
    end
  end

  // Detector state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      sr_q    <= '0;
      fill_q  <= '0;
      match_q <= 1'b0;
    end else begin
      sr_q    <= sr_d;
      fill_q  <= fill_d;
      match_q <= match_d;
    end
  end

  assign match     = match_q;
  assign match_nxt = match_d;

endmodule

// File: rtl/seq_det_ctrl.sv
// Session controller: config handshake, IDLE/RUN/DONE FSM, match and timeout counters.
// SEQ_DET_NONOVERLAP_EN selects non-overlapping detection inside the match core.
module seq_det_ctrl
  import seq_det_pkg::*;
#(
  parameter int MAX_LEN = DEF_MAX_LEN,
  parameter int CNT_W   = DEF_CNT_W,
  parameter int TMO_W   = DEF_TMO_W,
  localparam int LEN_W  = len_w(MAX_LEN)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cfg_valid,
  output logic               cfg_ready,
  input  logic [MAX_LEN-1:0] cfg_pattern,
  input  logic [LEN_W-1:0]   cfg_len,
  input  logic [CNT_W-1:0]   cfg_target,
  input  logic [TMO_W-1:0]   cfg_timeout,
  input  logic               start,
  input  logic               abort,
  input  logic               in_valid,
  input  logic               in,
  output logic               match,
  output logic [CNT_W-1:0]   match_cnt,
  output logic               busy,
  output logic               done,
  output logic               timeout_flag
);

  localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(MAX_LEN);

  state_t             state_q, state_d;
  logic [MAX_LEN-1:0] pattern_q, pattern_d;
  logic [LEN_W-1:0]   len_q, len_d, len_clamp_s;
  logic [CNT_W-1:0]   target_q, target_d, match_cnt_q, match_cnt_d, cnt_inc_s;
  logic [TMO_W-1:0]   timeout_q, timeout_d, tmo_cnt_q, tmo_cnt_d;
  logic               busy_q, busy_d, done_q, done_d, flag_q, flag_d, cfg_ready_q, cfg_ready_d;
  logic               cfg_fire_s, run_entry_s, tgt_hit_s, tmo_hit_s, tmo_exit_s;
  logic               core_valid_s, match_nxt_s;

  assign core_valid_s = in_valid & (state_q == ST_RUN) & ~abort;

  seq_det_match_core #(.MAX_LEN(MAX_LEN)) u_core (
    .clk       (clk),
    .rst       (rst),
    .clr       (run_entry_s),
    .in_valid  (core_valid_s),
    .in        (in),
    .pattern   (pattern_q),
    .len       (len_q),
    .match     (match),
    .match_nxt (match_nxt_s)
  );

  // Config capture with length clamped into 1..MAX_LEN.
  always_comb begin
    cfg_fire_s = cfg_valid & cfg_ready_q;
    if (cfg_len == '0)          len_clamp_s = LEN_W'(1);
    else if (cfg_len > LEN_MAX) len_clamp_s = LEN_MAX;
    else                        len_clamp_s = cfg_len;
    if (cfg_fire_s) begin
      pattern_d = cfg_pattern;
      len_d     = len_clamp_s;
      target_d  = cfg_target;
      timeout_d = cfg_timeout;
    end else begin
      pattern_d = pattern_q;
      len_d     = len_q;
      target_d  = target_q;
      timeout_d = timeout_q;
    end
  end

  // Next state: abort beats target, target beats timeout, start only outside RUN.
  always_comb begin
    state_d     = state_q;
    run_entry_s = 1'b0;
    tmo_exit_s  = 1'b0;
    if (match_cnt_q == {CNT_W{1'b1}}) cnt_inc_s = match_cnt_q;
    else                              cnt_inc_s = match_cnt_q + CNT_W'(1);
    tgt_hit_s = match_nxt_s && (target_q != '0) && (cnt_inc_s == target_q);
    tmo_hit_s = (timeout_q != '0) && !match_nxt_s && (tmo_cnt_q == (timeout_q - TMO_W'(1)));
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d     = ST_RUN;
          run_entry_s = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (abort)          state_d = ST_IDLE;
        else if (tgt_hit_s) state_d = ST_DONE;
        else if (tmo_hit_s) begin
          state_d    = ST_DONE;
          tmo_exit_s = 1'b1;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_DONE: begin
        if (abort) state_d = ST_IDLE;
        else if (start) begin
          state_d     = ST_RUN;
          run_entry_s = 1'b1;
        end else begin
          state_d = ST_DONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Session counters and registered status outputs.
  always_comb begin
    if (run_entry_s)      match_cnt_d = '0;
    else if (match_nxt_s) match_cnt_d = cnt_inc_s;
    else                  match_cnt_d = match_cnt_q;

    if (run_entry_s)              tmo_cnt_d = '0;
    else if (state_q == ST_RUN) begin
      if (match_nxt_s) tmo_cnt_d = '0;
      else             tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
    end else begin
      tmo_cnt_d = tmo_cnt_q;
    end

    if (state_d != ST_DONE)      flag_d = 1'b0;
    else if (state_q == ST_RUN)  flag_d = tmo_exit_s;
    else                         flag_d = flag_q;

    busy_d      = (state_d == ST_RUN);
    done_d      = (state_d == ST_DONE);
    cfg_ready_d = (state_d != ST_RUN);
  end

  // All state registers; synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      pattern_q   <= '0;
      len_q       <= LEN_W'(1);
      target_q    <= '0;
      timeout_q   <= '0;
      match_cnt_q <= '0;
      tmo_cnt_q   <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      flag_q      <= 1'b0;
      cfg_ready_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      pattern_q   <= pattern_d;
      len_q       <= len_d;
      target_q    <= target_d;
      timeout_q   <= timeout_d;
      match_cnt_q <= match_cnt_d;
      tmo_cnt_q   <= tmo_cnt_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      flag_q      <= flag_d;
      cfg_ready_q <= cfg_ready_d;
    end
  end

  assign match_cnt    = match_cnt_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign timeout_flag = flag_q;
  assign cfg_ready    = cfg_ready_q;

endmodule

// File: tb/tb_seq_det_ctrl.sv
// Scoreboard bench for seq_det_ctrl: session-level reference model, directed scenarios, random phase.
module tb_seq_det_ctrl;
  localparam int MAX_LEN = 8;
  localparam int CNT_W   = 8;
  localparam int TMO_W   = 16;
  localparam int LEN_W   = $clog2(MAX_LEN + 1);

  logic clk = 1'b0;
  logic rst, cfg_valid, cfg_ready, start, abort, in_valid, in_bit;
  logic match, busy, done, timeout_flag;
  logic [MAX_LEN-1:0] cfg_pattern;
  logic [LEN_W-1:0]   cfg_len;
  logic [CNT_W-1:0]   cfg_target, match_cnt;
  logic [TMO_W-1:0]   cfg_timeout;

  always #5 clk = ~clk;

  seq_det_ctrl #(.MAX_LEN(MAX_LEN), .CNT_W(CNT_W), .TMO_W(TMO_W)) dut (
    .clk(clk), .rst(rst), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_pattern(cfg_pattern), .cfg_len(cfg_len), .cfg_target(cfg_target),
    .cfg_timeout(cfg_timeout), .start(start), .abort(abort),
    .in_valid(in_valid), .in(in_bit), .match(match), .match_cnt(match_cnt),
    .busy(busy), .done(done), .timeout_flag(timeout_flag)
  );

  // Reference model: session flags plus the history of bits received this session.
  bit m_run, m_done, m_flag, m_match;
  int m_pat, m_len, m_tgt, m_tmo, m_cnt, m_quiet;
  int hist[$];
  logic [12:0] exp_q[$];
  int checks = 0, passes = 0, cyc = 0;

  task automatic model_step(output logic [12:0] e);
    bit hit;
    int v;
    if (rst) begin
      m_run = 0; m_done = 0; m_flag = 0; m_match = 0;
      m_pat = 0; m_len = 1; m_tgt = 0; m_tmo = 0; m_cnt = 0; m_quiet = 0;
      hist.delete();
    end else begin
      if (cfg_valid && !m_run) begin
        m_pat = int'(cfg_pattern);
        m_len = (cfg_len == 0) ? 1 : ((int'(cfg_len) > MAX_LEN) ? MAX_LEN : int'(cfg_len));
        m_tgt = int'(cfg_target);
        m_tmo = int'(cfg_timeout);
      end
      m_match = 0;
      if (m_run) begin
        if (abort) begin
          m_run = 0; m_done = 0; m_flag = 0;
        end else begin
          hit = 0;
          if (in_valid) begin
            hist.push_back(int'(in_bit));
            if (hist.size() > 16) void'(hist.pop_front());
            if (hist.size() >= m_len) begin
              v = 0;
              for (int k = hist.size() - m_len; k < hist.size(); k++) v = v * 2 + hist[k];
              hit = (v == (m_pat % (1 << m_len)));
            end
          end
          if (hit) begin
            m_match = 1;
            if (m_cnt < 255) m_cnt++;
            m_quiet = 0;
`ifdef SEQ_DET_NONOVERLAP_EN
            hist.delete();
`endif
            if (m_tgt != 0 && m_cnt == m_tgt) begin m_run = 0; m_done = 1; end
          end else if (m_tmo != 0 && m_quiet + 1 == m_tmo) begin
            m_run = 0; m_done = 1; m_flag = 1;
          end else begin
            m_quiet++;
          end
        end
      end else if (m_done && abort) begin
        m_done = 0; m_flag = 0;
      end else if (start) begin
        m_run = 1; m_done = 0; m_flag = 0; m_cnt = 0; m_quiet = 0;
        hist.delete();
      end
    end
    e = {m_match, 8'(m_cnt), m_run, m_done, m_flag, !m_run};
  endtask

  task automatic tick();
    logic [12:0] e;
    model_step(e);
    @(posedge clk);
    exp_q.push_back(e);
    #2;
    cyc++;
  endtask

  // Monitor: compare DUT outputs against the oldest expected entry.
  always @(negedge clk) begin
    logic [12:0] e, act;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      act = {match, match_cnt, busy, done, timeout_flag, cfg_ready};
      checks++;
      if (act === e) passes++;
      else $display("FAIL outputs cycle %0d {match,cnt,busy,done,tflag,ready}: got %b_%h_%b%b%b%b required %b_%h_%b%b%b%b",
                    cyc, act[12], act[11:4], act[3], act[2], act[1], act[0],
                    e[12], e[11:4], e[3], e[2], e[1], e[0]);
    end
  end

  task automatic idle_inputs();
    rst = 0; cfg_valid = 0; start = 0; abort = 0; in_valid = 0; in_bit = 0;
  endtask

  task automatic cfg(input int pat, input int len, input int tgt, input int tmo, input bit st);
    cfg_valid = 1; cfg_pattern = MAX_LEN'(pat); cfg_len = LEN_W'(len);
    cfg_target = CNT_W'(tgt); cfg_timeout = TMO_W'(tmo); start = st;
    tick();
    cfg_valid = 0; start = 0;
  endtask

  task automatic stream(input logic [15:0] bits, input int n);
    logic [15:0] b;
    b = bits;
    for (int i = n - 1; i >= 0; i--) begin
      in_valid = 1; in_bit = b[i];
      tick();
    end
    in_valid = 0;
  endtask

  task automatic go();
    start = 1; tick(); start = 0;
  endtask

  initial begin
    idle_inputs();
    cfg_pattern = '0; cfg_len = '0; cfg_target = '0; cfg_timeout = '0;
    rst = 1; tick(); tick(); rst = 0;
    tick();

    // Overlapping 1101 stream, no target, no timeout.
    cfg(4'b1101, 4, 0, 0, 0);
    go(); stream(16'b1101101, 7); tick(); tick();
    abort = 1; tick(); abort = 0;

    // Target 2 with config and start together, then restart.
    cfg(4'b1101, 4, 2, 0, 1);
    stream(16'b1101101, 7); tick();
    go(); tick();
    abort = 1; tick(); abort = 0;

    // Timeout of 5 on an idle stream.
    cfg(4'b1101, 4, 0, 5, 1);
    repeat (8) tick();

    // len 0 clamps to 1; config offered during RUN must be refused.
    cfg(1, 0, 0, 0, 1);
    stream(16'b1101, 4);
    cfg(0, 3, 1, 2, 0);
    stream(16'b11, 2);
    abort = 1; tick(); abort = 0;
    go(); stream(16'b101, 3);

    // Abort together with start after two matches, stream continues.
    abort = 1; tick(); abort = 0;
    cfg(4'b1101, 4, 0, 0, 1);
    stream(16'b1101101, 7);
    abort = 1; start = 1; in_valid = 1; in_bit = 1; tick();
    abort = 0; start = 0;
    stream(16'b1101101, 7); tick();

    // Reset on the cycle a match completes.
    go(); stream(16'b110, 3);
    in_valid = 1; in_bit = 1; rst = 1; tick();
    idle_inputs(); tick(); tick();

    // Random phase.
    for (int n = 0; n < 3000; n++) begin
      rst         = ($urandom_range(999) < 3);
      cfg_valid   = ($urandom_range(99) < 10);
      cfg_pattern = MAX_LEN'($urandom);
      cfg_len     = LEN_W'($urandom_range(15));
      cfg_target  = CNT_W'($urandom_range(3));
      cfg_timeout = TMO_W'($urandom_range(12));
      start       = ($urandom_range(99) < 5);
      abort       = ($urandom_range(99) < 2);
      in_valid    = ($urandom_range(99) < 70);
      in_bit      = 1'($urandom);
      tick();
    end
    idle_inputs();
    tick();

    @(negedge clk); #1;
    checks++;
    if (exp_q.size() == 0) passes++;
    else $display("FAIL drain: %0d entries left, required 0", exp_q.size());
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
